// File: rtl/dphy_pkt_parser.sv
// CSI-2 packet parser: decodes and ECC-checks the packet header, then streams
// long-packet payload with the CRC stripped and per-lane byte enables.
module dphy_pkt_parser #(
  parameter int unsigned DATA_LANES = 4
) (
  input  logic                       byte_clk_i,
  input  logic                       rst_n_i,
  input  logic [DATA_LANES-1:0][7:0] word_i,
  input  logic                       valid_i,
  output logic                       pkt_done_o,
  output logic                       hdr_valid_o,
  output logic                       hdr_long_o,
  output logic [1:0]                 hdr_vc_o,
  output logic [5:0]                 hdr_dt_o,
  output logic [15:0]                hdr_wc_o,
  output logic                       ecc_err_o,
  output logic [DATA_LANES-1:0][7:0] data_o,
  output logic [DATA_LANES-1:0]      byte_en_o,
  output logic                       data_valid_o,
  output logic                       data_last_o
);

  localparam int unsigned HDR_WORDS = 4 / DATA_LANES;
  localparam logic [16:0] LANES_W   = 17'(DATA_LANES);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, WAIT_IDLE} state_t;

  state_t                  state_q, state_d;
  logic [3:0][7:0]         hdr_sr, hdr_c;
  logic [1:0]              hdr_cnt;
  logic [16:0]             rem;
  logic                    accept, hdr_phase, hdr_done, ecc_bad, is_long;
  logic                    rem_end, last_c;
  logic [23:0]             hdr_data;
  logic [5:0]              ecc_calc;
  logic [DATA_LANES-1:0]   lane_en;

  assign accept    = valid_i && (state_q != WAIT_IDLE);
  assign hdr_phase = (state_q == IDLE) || (state_q == HDR);
  assign hdr_done  = accept && hdr_phase && (hdr_cnt == 2'(HDR_WORDS - 1));

  // Header bytes seen so far merged with the word being accepted now
  always_comb begin
    hdr_c = hdr_sr;
    for (int i = 0; i < int'(DATA_LANES); i++) begin
      hdr_c[2'(int'(hdr_cnt) * int'(DATA_LANES) + i)] = word_i[i];
    end
  end

  // CSI-2 6-bit header ECC over DI, WC_L, WC_H
  assign hdr_data    = {hdr_c[2], hdr_c[1], hdr_c[0]};
  assign ecc_calc[0] = ^(hdr_data & 24'hF12CB7);
  assign ecc_calc[1] = ^(hdr_data & 24'hF2555B);
  assign ecc_calc[2] = ^(hdr_data & 24'h749A6D);
  assign ecc_calc[3] = ^(hdr_data & 24'hB8E38E);
  assign ecc_calc[4] = ^(hdr_data & 24'hDF03F0);
  assign ecc_calc[5] = ^(hdr_data & 24'hEFFC00);
  assign ecc_bad     = (hdr_c[3][5:0] != ecc_calc) || (hdr_c[3][7:6] != 2'b00);
  assign is_long     = hdr_c[0][5:0] >= 6'h10;

  // rem counts payload+CRC bytes still to come; lane i is payload while rem > i+2
  always_comb begin
    lane_en = '0;
    for (int i = 0; i < int'(DATA_LANES); i++) begin
      lane_en[i] = rem > 17'(i + 2);
    end
  end

  assign rem_end = rem <= LANES_W;
  assign last_c  = (rem >= 17'd3) && (rem <= LANES_W + 17'd2);

  always_ff @(posedge byte_clk_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pkt_done_o = 1'b0;
    case (state_q)
      IDLE, HDR: begin
        if (hdr_done) begin
          if (ecc_bad || !is_long) begin
            state_d    = WAIT_IDLE;
            pkt_done_o = 1'b1;
          end else begin
            state_d = PAYLOAD;
          end
        end else if (accept) begin
          state_d = HDR;
        end
      end
      PAYLOAD: begin
        if (accept && rem_end) begin
          state_d    = WAIT_IDLE;
          pkt_done_o = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (!valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a packet cut short by reset must not re-arm the aligner
    if (!rst_n_i) pkt_done_o = 1'b0;
  end

  always_ff @(posedge byte_clk_i) begin
    if (!rst_n_i) begin
      hdr_sr       <= '0;
      hdr_cnt      <= '0;
      rem          <= '0;
      hdr_valid_o  <= 1'b0;
      hdr_long_o   <= 1'b0;
      hdr_vc_o     <= '0;
      hdr_dt_o     <= '0;
      hdr_wc_o     <= '0;
      ecc_err_o    <= 1'b0;
      data_o       <= '0;
      byte_en_o    <= '0;
      data_valid_o <= 1'b0;
      data_last_o  <= 1'b0;
    end else begin
      hdr_valid_o  <= 1'b0;
      ecc_err_o    <= 1'b0;
      data_o       <= '0;
      byte_en_o    <= '0;
      data_valid_o <= 1'b0;
      data_last_o  <= 1'b0;

      if (accept && hdr_phase) begin
        hdr_sr  <= hdr_c;
        hdr_cnt <= hdr_done ? 2'd0 : hdr_cnt + 2'd1;
      end

      if (hdr_done) begin
        rem <= {1'b0, hdr_c[2], hdr_c[1]} + 17'd2;
        if (ecc_bad) begin
          ecc_err_o <= 1'b1;
        end else begin
          hdr_valid_o <= 1'b1;
          hdr_long_o  <= is_long;
          hdr_vc_o    <= hdr_c[0][7:6];
          hdr_dt_o    <= hdr_c[0][5:0];
          hdr_wc_o    <= {hdr_c[2], hdr_c[1]};
        end
      end

      if (accept && (state_q == PAYLOAD)) begin
        rem          <= rem_end ? 17'd0 : rem - LANES_W;
        byte_en_o    <= lane_en;
        data_valid_o <= |lane_en;
        data_last_o  <= last_c;
        for (int i = 0; i < int'(DATA_LANES); i++) begin
          data_o[i] <= lane_en[i] ? word_i[i] : 8'h00;
        end
      end
    end
  end

endmodule

// File: tb/tb_dphy_pkt_parser.sv
// Scoreboard bench for dphy_pkt_parser: a 4-lane and a 2-lane instance driven
// with directed packets; expectations are queued and checked by a monitor.
module tb_dphy_pkt_parser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic done; logic zero; } cyc_t;
  typedef struct packed { logic lng; logic [1:0] vc; logic [5:0] dt; logic [15:0] wc; } hdr_t;
  typedef struct packed { logic [31:0] data; logic [3:0] be; logic last; } dat_t;

  // ECC contribution of each header data bit D0..D23
  localparam logic [5:0] ECC_COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  // 4-lane instance
  logic            rst4 = 1'b0, v4 = 1'b0;
  logic [3:0][7:0] w4 = '0;
  logic            pd4, hv4, hl4, ee4, dv4, dl4;
  logic [1:0]      vc4;
  logic [5:0]      dt4;
  logic [15:0]     wc4;
  logic [3:0][7:0] d4;
  logic [3:0]      be4;

  // 2-lane instance
  logic            rst2 = 1'b0, v2 = 1'b0;
  logic [1:0][7:0] w2 = '0;
  logic            pd2, hv2, hl2, ee2, dv2, dl2;
  logic [1:0]      vc2;
  logic [5:0]      dt2;
  logic [15:0]     wc2;
  logic [1:0][7:0] d2;
  logic [1:0]      be2;

  dphy_pkt_parser #(.DATA_LANES(4)) dut4 (
    .byte_clk_i(clk), .rst_n_i(rst4), .word_i(w4), .valid_i(v4),
    .pkt_done_o(pd4), .hdr_valid_o(hv4), .hdr_long_o(hl4), .hdr_vc_o(vc4),
    .hdr_dt_o(dt4), .hdr_wc_o(wc4), .ecc_err_o(ee4), .data_o(d4),
    .byte_en_o(be4), .data_valid_o(dv4), .data_last_o(dl4));

  dphy_pkt_parser #(.DATA_LANES(2)) dut2 (
    .byte_clk_i(clk), .rst_n_i(rst2), .word_i(w2), .valid_i(v2),
    .pkt_done_o(pd2), .hdr_valid_o(hv2), .hdr_long_o(hl2), .hdr_vc_o(vc2),
    .hdr_dt_o(dt2), .hdr_wc_o(wc2), .ecc_err_o(ee2), .data_o(d2),
    .byte_en_o(be2), .data_valid_o(dv2), .data_last_o(dl2));

  int checks = 0;
  int passes = 0;

  cyc_t pq [2][$];
  hdr_t hq [2][$];
  bit   eq [2][$];
  dat_t dq [2][$];

  function automatic void check(bit ok, string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  function automatic logic [5:0] ecc_f(logic [23:0] d);
    logic [5:0] e = '0;
    for (int i = 0; i < 24; i++) if (d[i]) e ^= ECC_COL[i];
    return e;
  endfunction

  function automatic logic [31:0] mask(logic [3:0] be);
    logic [31:0] m = '0;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

  // one driven cycle; records the expected pkt_done and whether outputs must be all-zero
  task automatic cyc(int u, bit r, bit v, logic [31:0] w, bit d, bit z);
    cyc_t c;
    @(posedge clk); #1;
    if (u == 0) begin rst4 = r; v4 = v; w4 = w; end
    else        begin rst2 = r; v2 = v; w2 = w[15:0]; end
    c.done = d;
    c.zero = z;
    pq[u].push_back(c);
  endtask

  task automatic send_pkt(int u, logic [1:0] vc, logic [5:0] dt, logic [15:0] wc,
                          logic [7:0] base, bit flip, bit ecc_hi, int abort, bit extra);
    int          lanes;
    int          nw;
    logic [7:0]  s [$];
    logic [7:0]  di, ecc;
    bit          lng, err, last;
    hdr_t        h;
    dat_t        e;
    logic [31:0] w;
    logic [3:0]  be;
    lanes = (u == 0) ? 4 : 2;
    di    = {vc, dt};
    ecc   = {2'b00, ecc_f({wc, di})} | (ecc_hi ? 8'h40 : 8'h00);
    err   = flip || ecc_hi;
    lng   = dt >= 6'h10;
    s.push_back(di);
    s.push_back(wc[7:0] ^ (flip ? 8'h04 : 8'h00));
    s.push_back(wc[15:8]);
    s.push_back(ecc);
    if (err) eq[u].push_back(1'b1);
    else begin
      h.lng = lng; h.vc = vc; h.dt = dt; h.wc = wc;
      hq[u].push_back(h);
    end
    if (lng && !err) begin
      for (int j = 0; j < int'(wc); j++) s.push_back(8'(int'(base) + j));
      s.push_back(8'hC3);
      s.push_back(8'h5C);
      while (s.size() % lanes != 0) s.push_back(8'hEE);
    end
    nw = s.size() / lanes;
    for (int k = 0; k < nw; k++) begin
      if (abort != 0 && k == abort) begin
        cyc(u, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        cyc(u, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        return;
      end
      w = '0; be = '0; last = 1'b0;
      for (int i = 0; i < lanes; i++) begin
        int g;
        g = k * lanes + i;
        w[i*8 +: 8] = s[g];
        if (lng && !err && g >= 4 && (g - 4) < int'(wc)) begin
          be[i] = 1'b1;
          if ((g - 4) == int'(wc) - 1) last = 1'b1;
        end
      end
      if (be != 4'b0) begin
        e.data = w; e.be = be; e.last = last;
        dq[u].push_back(e);
      end
      cyc(u, 1'b1, 1'b1, w, k == nw - 1, 1'b0);
    end
    if (extra) cyc(u, 1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0);
    cyc(u, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic mon(int u, logic pd, logic hv, logic hl, logic [1:0] vc, logic [5:0] dt,
                     logic [15:0] wc, logic ee, logic [31:0] d, logic [3:0] be,
                     logic dv, logic dl);
    cyc_t        c;
    hdr_t        h;
    dat_t        e;
    logic [31:0] m;
    if (pq[u].size() > 0) begin
      c = pq[u].pop_front();
      check(pd === c.done, $sformatf("u%0d pkt_done", u), 64'(pd), 64'(c.done));
      if (c.zero) begin
        check({hv, hl, vc, dt, wc, ee, be, dv, dl} === '0, $sformatf("u%0d rst_zero_ctl", u),
              64'({hv, hl, vc, dt, wc, ee, be, dv, dl}), 64'(0));
        check(d === 32'h0, $sformatf("u%0d rst_zero_data", u), 64'(d), 64'(0));
      end
    end
    if (hv === 1'b1) begin
      if (hq[u].size() == 0) check(1'b0, $sformatf("u%0d unexpected hdr_valid", u), 64'(1), 64'(0));
      else begin
        h = hq[u].pop_front();
        check({hl, vc, dt, wc} === {h.lng, h.vc, h.dt, h.wc}, $sformatf("u%0d hdr_fields", u),
              64'({hl, vc, dt, wc}), 64'({h.lng, h.vc, h.dt, h.wc}));
      end
    end
    if (ee === 1'b1) begin
      check(eq[u].size() > 0, $sformatf("u%0d ecc_err", u), 64'(1), 64'(eq[u].size() > 0));
      if (eq[u].size() > 0) void'(eq[u].pop_front());
    end
    if (dv === 1'b1) begin
      if (dq[u].size() == 0) check(1'b0, $sformatf("u%0d unexpected data_valid", u), 64'(d), 64'(0));
      else begin
        e = dq[u].pop_front();
        m = mask(e.be);
        check(be === e.be && dl === e.last && (d & m) === (e.data & m), $sformatf("u%0d payload", u),
              64'({dl, be, d & m}), 64'({e.last, e.be, e.data & m}));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, pd4, hv4, hl4, vc4, dt4, wc4, ee4, d4, be4, dv4, dl4);
    mon(1, pd2, hv2, hl2, vc2, dt2, wc2, ee2, {16'h0, d2}, {2'b00, be2}, dv2, dl2);
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      begin
        repeat (2) cyc(0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        send_pkt(0, 2'd0, 6'h00, 16'h0001, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        send_pkt(0, 2'd0, 6'h2A, 16'd6,    8'hA0, 1'b0, 1'b0, 0, 1'b0);
        send_pkt(0, 2'd0, 6'h2B, 16'd4,    8'h10, 1'b0, 1'b0, 0, 1'b0);
        send_pkt(0, 2'd0, 6'h2C, 16'd0,    8'h00, 1'b0, 1'b0, 0, 1'b0);
        send_pkt(0, 2'd2, 6'h2D, 16'd2,    8'h55, 1'b0, 1'b0, 0, 1'b1);
        send_pkt(0, 2'd0, 6'h2A, 16'd6,    8'hA0, 1'b1, 1'b0, 0, 1'b1);
        send_pkt(0, 2'd1, 6'h2A, 16'd6,    8'hB0, 1'b0, 1'b0, 0, 1'b0);
        send_pkt(0, 2'd3, 6'h01, 16'h1234, 8'h00, 1'b0, 1'b1, 0, 1'b0);
        send_pkt(0, 2'd0, 6'h1E, 16'd64,   8'h40, 1'b0, 1'b0, 3, 1'b0);
        send_pkt(0, 2'd0, 6'h2A, 16'd6,    8'hC8, 1'b0, 1'b0, 0, 1'b0);
      end
      begin
        repeat (2) cyc(1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        send_pkt(1, 2'd1, 6'h02, 16'h00FF, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        send_pkt(1, 2'd0, 6'h2A, 16'd6,    8'hA0, 1'b0, 1'b0, 0, 1'b0);
        send_pkt(1, 2'd2, 6'h24, 16'd5,    8'h70, 1'b0, 1'b0, 0, 1'b1);
        send_pkt(1, 2'd0, 6'h2A, 16'd6,    8'hA0, 1'b1, 1'b0, 0, 1'b0);
        send_pkt(1, 2'd3, 6'h2B, 16'd4,    8'h90, 1'b0, 1'b0, 0, 1'b0);
        send_pkt(1, 2'd0, 6'h1E, 16'd64,   8'h40, 1'b0, 1'b0, 5, 1'b0);
        send_pkt(1, 2'd0, 6'h2A, 16'd6,    8'hD0, 1'b0, 1'b0, 0, 1'b0);
      end
    join
    repeat (3) @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      check(hq[u].size() == 0, $sformatf("u%0d missing hdr_valid", u), 64'(hq[u].size()), 64'(0));
      check(eq[u].size() == 0, $sformatf("u%0d missing ecc_err", u), 64'(eq[u].size()), 64'(0));
      check(dq[u].size() == 0, $sformatf("u%0d missing payload", u), 64'(dq[u].size()), 64'(0));
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
